// File: rtl/main_mem_pkg.sv
// Shared types and defaults for the main-memory controller.
// Holds the FSM encoding and the sizing helper for the latency counter.
package main_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_RD_LAT = 4;
   localparam int DEF_WR_LAT = 4;
   localparam int DEF_IO_LAT = 8;

   // Counter width that can hold the largest of the three latencies.
   function automatic int lat_width(input int rd_lat, input int wr_lat, input int io_lat);
      int m;
      m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
      m = (m > io_lat) ? m : io_lat;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

   localparam int DEF_LAT_W = lat_width(DEF_RD_LAT, DEF_WR_LAT, DEF_IO_LAT);

endpackage

// File: rtl/main_mem_ctrl_ram.sv
// Single-port synchronous word RAM, read-first: dout shows the old word
// when a write and a read hit the same address in one cycle.
module mem_ram_sp #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       din,
   output logic [31:0]       dout
);

   logic [31:0] mem [0:(1 << ADDR_W) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/main_mem_ctrl.sv
// Multi-cycle main-memory controller: accepts one word request, waits a
// programmable latency, then pulses mem_ready for a single cycle.
module main_mem_ctrl
   import main_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int WR_LAT = DEF_WR_LAT,
   parameter int IO_LAT = DEF_IO_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_access,
   input  logic        mem_write,
   input  logic [31:0] mem_a,
   input  logic [31:0] mem_st_data,
   input  logic        io,
   output logic [31:0] mem_data,
   output logic        mem_ready,
   output logic        busy
);

   localparam int CNT_W = lat_width(RD_LAT, WR_LAT, IO_LAT);
   localparam logic [CNT_W-1:0] RD_L    = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] WR_L    = CNT_W'(WR_LAT);
   localparam logic [CNT_W-1:0] IO_L    = CNT_W'(IO_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  lat;
   logic              accept;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       data_q;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [31:0]       ram_dout;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{mem_a[31:ADDR_W+2], mem_a[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      lat     = io ? IO_L : (mem_write ? WR_L : RD_L);
      case (state_q)
         IDLE: begin
            if (mem_access) begin
               accept = 1'b1;
               if (lat == CNT_ONE) begin
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
                  cnt_d   = lat - CNT_ONE;
               end
            end
         end
         BUSY: begin
            // A dropped strobe abandons the request before anything commits.
            if (!mem_access) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= mem_write;
            addr_q  <= mem_a[ADDR_W+1:2];
            wdata_q <= mem_st_data;
         end
         if (state_q == DONE && !wr_q) begin
            data_q <= ram_dout;
         end
      end
   end

   // In IDLE the live address drives the RAM so a latency-1 read is
   // issued at acceptance; otherwise the latched address is used.
   assign ram_addr = (state_q == IDLE) ? mem_a[ADDR_W+1:2] : addr_q;
   assign ram_we   = (state_q == DONE) && wr_q && !rst;

   mem_ram_sp #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk (clk),
      .we  (ram_we),
      .addr(ram_addr),
      .din (wdata_q),
      .dout(ram_dout)
   );

   assign mem_ready = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign mem_data  = (state_q == DONE && !wr_q) ? ram_dout : data_q;

endmodule
